// File: rtl/usb_tx_arbiter_if.sv
// Handshake bundle between the USB TX arbiter, its two requesters (wave FIFO, cmdproc)
// and the USB write port. The arbiter connects through the slave modport.
interface usb_tx_arbiter_if #(
    parameter int unsigned COUNT_W = 12
);
    logic               en;
    logic [COUNT_W-1:0] wave_count;
    logic [15:0]        wave_data;
    logic               wave_rd;
    logic               rsp_req;
    logic [15:0]        rsp_code;
    logic               full;
    logic               wr;
    logic [15:0]        wr_data;
    logic               rsp_drop;
    logic               busy;
    logic [15:0]        pkt_cnt;

    modport master (
        output en, wave_count, wave_data, rsp_req, rsp_code, full,
        input  wave_rd, wr, wr_data, rsp_drop, busy, pkt_cnt
    );

    modport slave (
        input  en, wave_count, wave_data, rsp_req, rsp_code, full,
        output wave_rd, wr, wr_data, rsp_drop, busy, pkt_cnt
    );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Packetising arbiter sharing the 16-bit USB write path between wave bursts and
// command responses; responses win only at packet boundaries.
module usb_tx_arbiter #(
    parameter int unsigned WAVE_BURST = 256,
    parameter int unsigned COUNT_W    = 12,
    parameter logic [15:0] HDR_WAVE   = 16'hA55A,
    parameter logic [15:0] HDR_RSP    = 16'h5AA5
) (
    input logic clk,
    input logic rst,
    usb_tx_arbiter_if.slave bus
);
    localparam logic [COUNT_W-1:0] BURST = COUNT_W'(WAVE_BURST);

    // Headers are registered on the IDLE exit edge; RSP_C/RSP_N name the word still owed.
    typedef enum logic [1:0] {IDLE, RSP_C, RSP_N, WAVE_D} state_t;

    state_t             state, state_nxt;
    logic               rsp_pend;
    logic [15:0]        rsp_code_q;
    logic [COUNT_W-1:0] rd_left, wr_left;
    logic               rd_d1;
    logic               wr_q;
    logic [15:0]        wr_data_q;
    logic               drop_q;
    logic [15:0]        pkt_cnt_q;

    logic               wr_nxt;
    logic [15:0]        data_nxt;
    logic               load_burst;
    logic               rsp_clr;
    logic               pkt_done;
    logic               rd;

    always_comb begin
        state_nxt  = state;
        wr_nxt     = 1'b0;
        data_nxt   = wr_data_q;
        load_burst = 1'b0;
        rsp_clr    = 1'b0;
        pkt_done   = 1'b0;
        rd         = 1'b0;
        case (state)
            IDLE: begin
                if (rsp_pend && !bus.full) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = HDR_RSP;
                    state_nxt = RSP_C;
                end else if (!rsp_pend && bus.en && bus.wave_count >= BURST && !bus.full) begin
                    wr_nxt     = 1'b1;
                    data_nxt   = HDR_WAVE;
                    load_burst = 1'b1;
                    state_nxt  = WAVE_D;
                end
            end
            RSP_C: begin
                if (!bus.full) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = rsp_code_q;
                    rsp_clr   = 1'b1;
                    state_nxt = RSP_N;
                end
            end
            RSP_N: begin
                // The output register still holds the code, so a response latched
                // during RSP_C exit cannot corrupt the inverted copy.
                if (!bus.full) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = ~wr_data_q;
                    pkt_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAVE_D: begin
                rd = !bus.full && (rd_left != '0);
                if (rd_d1) begin
                    wr_nxt   = 1'b1;
                    data_nxt = bus.wave_data;
                    if (wr_left == COUNT_W'(1)) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            rsp_pend   <= 1'b0;
            rsp_code_q <= '0;
            rd_left    <= '0;
            wr_left    <= '0;
            rd_d1      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_q      <= wr_nxt;
            wr_data_q <= data_nxt;
            rd_d1     <= rd;
            if (load_burst) begin
                rd_left <= BURST;
                wr_left <= BURST;
            end else begin
                if (rd)    rd_left <= rd_left - 1'b1;
                if (rd_d1) wr_left <= wr_left - 1'b1;
            end
            if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            drop_q <= bus.rsp_req && rsp_pend && !rsp_clr;
            if (bus.rsp_req && (!rsp_pend || rsp_clr)) begin
                rsp_pend   <= 1'b1;
                rsp_code_q <= bus.rsp_code;
            end else if (rsp_clr) begin
                rsp_pend <= 1'b0;
            end
        end
    end

    assign bus.wave_rd  = rd;
    assign bus.wr       = wr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rsp_drop = drop_q;
    assign bus.busy     = (state != IDLE);
    assign bus.pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: FIFO and sink models, a packet parser over the write stream,
// directed scenarios and a randomized phase.
module tb_usb_tx_arbiter;
    localparam int unsigned WB = 4;
    localparam int unsigned CW = 12;
    localparam logic [15:0] HW = 16'hA55A;
    localparam logic [15:0] HR = 16'h5AA5;

    logic clk = 1'b0;
    logic rst;

    usb_tx_arbiter_if #(.COUNT_W(CW)) bus ();

    usb_tx_arbiter #(
        .WAVE_BURST(WB),
        .COUNT_W   (CW),
        .HDR_WAVE  (HW),
        .HDR_RSP   (HR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] fifo[$];
    logic [15:0] rd_words[$];
    logic [15:0] exp_rsp[$];
    int          exp_cyc[$];
    int          pkt_types[$];
    int          model_pkts = 0;
    int          pmode = 0;
    int          wdone = 0;
    int          rd_seen = 0;
    int          first_rd_cyc = 0;
    int          drop_seen = 0;
    int          rd_total = 0;
    logic [15:0] cur_code = '0;
    logic        rd_q = 1'b0;
    logic        f1 = 1'b0, f2 = 1'b0;
    bit          drops_ok = 1'b0;
    bit          mon_on = 1'b0;

    logic        t1_wr [5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] t1_data [5] = '{16'h0000, 16'h0000, 16'h5AA5, 16'h0012, 16'hFFED};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_pkt();
        model_pkts++;
        check("pkt_cnt", 32'(bus.pkt_cnt), 32'(model_pkts & 16'hFFFF));
    endtask

    task automatic wait_pkts(input int tgt, input int bound, input string tag);
        int n = 0;
        while (model_pkts < tgt && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(model_pkts >= tgt), 32'd1);
    endtask

    task automatic wait_words(input int w, input int bound, input string tag);
        int n = 0;
        while (!(pmode == 3 && wdone >= w) && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(pmode == 3 && wdone >= w), 32'd1);
    endtask

    task automatic send_rsp(input logic [15:0] code, input bit accepted);
        bus.rsp_req  = 1'b1;
        bus.rsp_code = code;
        if (accepted) begin
            exp_rsp.push_back(code);
            exp_cyc.push_back(cyc);
        end
        tick();
        bus.rsp_req = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Wave FIFO: a read sampled in cycle k returns its word during cycle k+1.
    always begin
        @(posedge clk);
        #1;
        if (rd_q && fifo.size() > 0) begin
            bus.wave_data = fifo.pop_front();
            rd_words.push_back(bus.wave_data);
            rd_total++;
        end
        bus.wave_count = CW'(fifo.size());
    end

    // Packet parser over the USB write stream.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.wr) begin
                check("wr_after_full", 32'(f1 && f2), 32'd0);
                case (pmode)
                    0: begin
                        check("header", 32'(bus.wr_data == HR || bus.wr_data == HW), 32'd1);
                        if (bus.wr_data == HR) begin
                            pmode = 1;
                            pkt_types.push_back(1);
                        end else if (bus.wr_data == HW) begin
                            check("rsp_priority",
                                  32'(exp_cyc.size() > 0 && exp_cyc[0] <= cyc - 2), 32'd0);
                            pmode   = 3;
                            wdone   = 0;
                            rd_seen = 0;
                            pkt_types.push_back(0);
                        end
                    end
                    1: begin
                        check("rsp_queued", 32'(exp_rsp.size() != 0), 32'd1);
                        if (exp_rsp.size() != 0) begin
                            cur_code = exp_rsp.pop_front();
                            void'(exp_cyc.pop_front());
                            check("rsp_code", 32'(bus.wr_data), 32'(cur_code));
                        end
                        pmode = 2;
                    end
                    2: begin
                        logic [15:0] inv;
                        inv = ~cur_code;
                        check("rsp_inv", 32'(bus.wr_data), 32'(inv));
                        pmode = 0;
                        end_pkt();
                    end
                    default: begin
                        check("wave_word_read", 32'(rd_words.size() != 0), 32'd1);
                        if (rd_words.size() != 0)
                            check("wave_data", 32'(bus.wr_data), 32'(rd_words.pop_front()));
                        if (wdone == 0)
                            check("wave_latency", 32'(cyc - first_rd_cyc), 32'd2);
                        wdone++;
                        if (wdone == int'(WB)) begin
                            pmode = 0;
                            end_pkt();
                        end
                    end
                endcase
            end
            if (bus.wave_rd) begin
                check("rd_in_burst", 32'(pmode == 3 && rd_seen < int'(WB)), 32'd1);
                check("rd_while_full", 32'(bus.full), 32'd0);
                check("rd_fifo_nonempty", 32'(fifo.size() > 0), 32'd1);
                if (rd_seen == 0) first_rd_cyc = cyc;
                rd_seen++;
            end
            check("busy", 32'(bus.busy), 32'(pmode != 0));
            if (!drops_ok) check("no_drop", 32'(bus.rsp_drop), 32'd0);
            else if (bus.rsp_drop) drop_seen++;
        end
        rd_q = bus.wave_rd;
        f2   = f1;
        f1   = bus.full;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, rdb, d0, n;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.rsp_req  = 1'b0;
        bus.rsp_code = '0;
        bus.full     = 1'b0;
        bus.wave_data  = '0;
        bus.wave_count = '0;
        repeat (3) tick();

        // Reset state
        check("rst_wr", 32'(bus.wr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_drop", 32'(bus.rsp_drop), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
        check("rst_wave_rd", 32'(bus.wave_rd), 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;
        tick();

        // Single response: words in cycles 2, 3, 4
        bus.rsp_req  = 1'b1;
        bus.rsp_code = 16'h0012;
        exp_rsp.push_back(16'h0012);
        exp_cyc.push_back(cyc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t1_wr_c%0d", k), 32'(bus.wr), 32'(t1_wr[k]));
            if (t1_wr[k]) check($sformatf("t1_data_c%0d", k), 32'(bus.wr_data), 32'(t1_data[k]));
            tick();
            bus.rsp_req = 1'b0;
        end
        check("t1_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);

        // New request in the cycle the pending code is written is latched, not dropped
        base = model_pkts;
        send_rsp(16'hBEEF, 1'b1);
        tick();
        send_rsp(16'h1234, 1'b1);
        wait_pkts(base + 2, 40, "t1b_done");

        // Wave burst 1..4
        base = model_pkts;
        for (int i = 1; i <= 4; i++) fifo.push_back(16'(i));
        rdb = rd_total;
        t0  = pkt_types.size();
        bus.en = 1'b1;
        wait_pkts(base + 1, 40, "t2_done");
        bus.en = 1'b0;
        tick();
        tick();
        check("t2_reads", 32'(rd_total - rdb), 32'd4);
        check("t2_type", 32'(pkt_types.size() > t0 ? pkt_types[t0] : -1), 32'd0);
        check("t2_idle", 32'(bus.busy), 32'd0);

        // Collision: response mid-burst waits, then beats the next burst
        base = model_pkts;
        t0   = pkt_types.size();
        for (int i = 0; i < 8; i++) fifo.push_back(16'($urandom));
        bus.en = 1'b1;
        wait_words(2, 40, "t3_mid_burst");
        send_rsp(16'hC0DE, 1'b1);
        wait_pkts(base + 3, 80, "t3_done");
        bus.en = 1'b0;
        check("t3_order", 32'(pkt_types.size() >= t0 + 3 ?
              (pkt_types[t0] * 4 + pkt_types[t0+1] * 2 + pkt_types[t0+2]) : -1), 32'd2);

        // Back-pressure for 10 cycles mid-burst
        base = model_pkts;
        for (int i = 0; i < 4; i++) fifo.push_back(16'($urandom));
        bus.en = 1'b1;
        wait_words(1, 40, "t4_mid_burst");
        bus.full = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wr) n++;
        end
        tick();
        bus.full = 1'b0;
        check("t4_writes_after_full", 32'(n <= 2), 32'd1);
        wait_pkts(base + 1, 40, "t4_done");
        bus.en = 1'b0;

        // Double request during a burst: one drop pulse
        base = model_pkts;
        for (int i = 0; i < 4; i++) fifo.push_back(16'($urandom));
        drops_ok = 1'b1;
        d0 = drop_seen;
        bus.en = 1'b1;
        wait_words(0, 40, "t5_burst");
        send_rsp(16'h00A1, 1'b1);
        tick();
        tick();
        send_rsp(16'h00B2, 1'b0);
        wait_pkts(base + 2, 60, "t5_done");
        bus.en = 1'b0;
        tick();
        tick();
        check("t5_drops", 32'(drop_seen - d0), 32'd1);
        drops_ok = 1'b0;

        // Reset mid-burst
        for (int i = 0; i < 8; i++) fifo.push_back(16'($urandom));
        bus.en = 1'b1;
        wait_words(2, 40, "t6_mid_burst");
        rst = 1'b1;
        tick();
        #1;
        check("t6_wr", 32'(bus.wr), 32'd0);
        check("t6_wr_data", 32'(bus.wr_data), 32'd0);
        check("t6_drop", 32'(bus.rsp_drop), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
        check("t6_wave_rd", 32'(bus.wave_rd), 32'd0);
        pmode = 0;
        wdone = 0;
        rd_seen = 0;
        rd_words.delete();
        exp_rsp.delete();
        exp_cyc.delete();
        model_pkts = 0;
        rst = 1'b0;
        t0 = pkt_types.size();
        wait_pkts(1, 40, "t6_fresh_burst");
        check("t6_type", 32'(pkt_types.size() > t0 ? pkt_types[t0] : -1), 32'd0);
        bus.en = 1'b0;

        // Randomized traffic
        bus.en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (bus.full) begin
                if ($urandom_range(2) == 0) bus.full = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                bus.full = 1'b1;
            end
            if ($urandom_range(1) == 0 && fifo.size() < 40) fifo.push_back(16'($urandom));
            if ($urandom_range(49) == 0) bus.en = ~bus.en;
            if (bus.rsp_req) begin
                bus.rsp_req = 1'b0;
            end else if (exp_rsp.size() == 0 && $urandom_range(29) == 0) begin
                bus.rsp_req  = 1'b1;
                bus.rsp_code = 16'($urandom);
                exp_rsp.push_back(bus.rsp_code);
                exp_cyc.push_back(cyc);
            end
            tick();
        end
        bus.rsp_req = 1'b0;
        bus.full    = 1'b0;
        bus.en      = 1'b0;
        n = 0;
        while ((pmode != 0 || exp_rsp.size() != 0 || bus.busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain", 32'(pmode == 0 && exp_rsp.size() == 0), 32'd1);
        check("final_pkt_cnt", 32'(bus.pkt_cnt), 32'(model_pkts & 16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
